// File: rtl/mux_nx1_rr.sv
// N-channel WIDTH-bit selector with a registered output and valid/ready handshakes.
// Fixed mode picks the channel given by sel; round-robin mode arbitrates fairly.
module mux_nx1_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] c,
    input  logic [CHANNELS-1:0]       c_valid,
    output logic [CHANNELS-1:0]       c_ready,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_ch
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  ptr_nxt;
    logic             has_gnt;
    logic             ld;
    logic [WIDTH-1:0] gnt_data;
    int               idx;

    assign ld = !out_valid || out_ready;

    // Grant search; a sel that matches no channel index never grants.
    always_comb begin
        gnt     = '0;
        has_gnt = 1'b0;
        idx     = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i && c_valid[i]) begin
                    gnt     = SELW'(i);
                    has_gnt = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!has_gnt && c_valid[idx]) begin
                    gnt     = SELW'(idx);
                    has_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        c_ready  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt == SELW'(i)) gnt_data = c[i*WIDTH +: WIDTH];
            c_ready[i] = !rst && ld && has_gnt && (gnt == SELW'(i));
        end
    end

    assign ptr_nxt = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + 1'b1;

    // Output register stage: loads on ld, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (ld) begin
            if (has_gnt) begin
                out       <= gnt_data;
                out_ch    <= gnt;
                out_valid <= 1'b1;
                if (mode) ptr <= ptr_nxt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
